// File: rtl/cache_ctrl.sv
// cache_ctrl: controller for a 4-line x 4-word direct-mapped cache array.
// Serves CPU loads/stores, merges byte stores locally, writes back dirty lines
// and refills 128-bit lines from memory. Per-line dirty bits and shadow tags
// are kept here because the array exposes neither.
// Optional feature: define CACHE_CTRL_STATS_EN to add saturating hit/miss
// counters (stat_hits, stat_misses).
module cache_ctrl #(
    parameter int unsigned TAG_W  = 26,  // addr[31:6]; fixed by array geometry
    parameter int unsigned STAT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              c_write,
    output logic              c_comp,
    output logic              c_byte_access,
    output logic [1:0]        c_index,
    output logic [1:0]        c_word,
    output logic [1:0]        c_byte,
    output logic [TAG_W-1:0]  c_tag,
    output logic [31:0]       c_wdata,
    input  logic              c_hit,
    input  logic              c_valid,
    input  logic [31:0]       c_rdata,
`ifdef CACHE_CTRL_STATS_EN
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StMerge,
        StWbRead,
        StWbMem,
        StFillMem,
        StFillWrite
    } state_t;

    state_t             state_q, state_d;
    logic               req_we_q, req_byte_q;
    logic [31:0]        req_addr_q, req_wdata_q;
    logic [3:0]         dirty_q, dirty_d;
    logic [TAG_W-1:0]   shadow_tag_q [4];
    logic               shadow_we;
    logic [1:0]         cnt_q, cnt_d;
    logic [127:0]       line_q, line_d;
    logic               ack_gap_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               accept;

    logic [1:0]         idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               mem_fire;
    logic [31:0]        shifted;
    logic [31:0]        load_data;
    logic [31:0]        merge_data;

    assign idx       = req_addr_q[5:4];
    assign req_tag   = req_addr_q[31:6];
    assign hit       = c_hit & c_valid;
    assign mem_fire  = mem_req & mem_ack;
    assign accept    = (state_q == StIdle) & cpu_req;

    assign cpu_rdata     = rdata_q;
    assign cpu_done      = done_q;
    assign c_byte_access = 1'b0;
    assign c_index       = idx;
    assign c_byte        = req_addr_q[1:0];
    assign c_tag         = req_tag;
    assign mem_wdata     = line_q;

    // Byte-lane extraction for loads and byte insertion for read-modify-write stores.
    always_comb begin
        shifted    = c_rdata >> {req_addr_q[1:0], 3'b000};
        load_data  = req_byte_q ? {24'h000000, shifted[7:0]} : c_rdata;
        merge_data = c_rdata;
        merge_data[{req_addr_q[1:0], 3'b000} +: 8] = req_wdata_q[7:0];
    end

    // Next-state and array/memory interface decode.
    always_comb begin
        state_d   = state_q;
        dirty_d   = dirty_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        shadow_we = 1'b0;
        c_comp    = 1'b0;
        c_write   = 1'b0;
        c_word    = req_addr_q[3:2];
        c_wdata   = req_wdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {req_tag, idx, 4'b0000};

        unique case (state_q)
            StIdle: begin
                if (cpu_req) state_d = StCompare;
            end
            StCompare: begin
                c_comp  = 1'b1;
                c_write = req_we_q & ~req_byte_q;
                if (hit) begin
                    if (!req_we_q) begin
                        rdata_d = load_data;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (!req_byte_q) begin
                        dirty_d[idx] = 1'b1;
                        done_d       = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        state_d = StMerge;
                    end
                end else if (dirty_q[idx]) begin
                    cnt_d   = 2'd0;
                    state_d = StWbRead;
                end else begin
                    state_d = StFillMem;
                end
            end
            StMerge: begin
                c_write      = 1'b1;
                c_wdata      = merge_data;
                dirty_d[idx] = 1'b1;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
            StWbRead: begin
                c_word = cnt_q;
                line_d[{cnt_q, 5'b00000} +: 32] = c_rdata;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StWbMem;
            end
            StWbMem: begin
                mem_req  = ~ack_gap_q;
                mem_we   = 1'b1;
                mem_addr = {shadow_tag_q[idx], idx, 4'b0000};
                if (mem_fire) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = StFillMem;
                end
            end
            StFillMem: begin
                // ack_gap_q drops the request for one cycle after a write-back ack
                mem_req = ~ack_gap_q;
                if (mem_fire) begin
                    line_d  = mem_rdata;
                    cnt_d   = 2'd0;
                    state_d = StFillWrite;
                end
            end
            StFillWrite: begin
                c_write = 1'b1;
                c_word  = cnt_q;
                c_wdata = line_q[{cnt_q, 5'b00000} +: 32];
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    shadow_we = 1'b1;
                    state_d   = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, request latch and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            dirty_q     <= 4'b0000;
            cnt_q       <= 2'd0;
            line_q      <= '0;
            ack_gap_q   <= 1'b0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            req_we_q    <= 1'b0;
            req_byte_q  <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            ack_gap_q <= mem_fire;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            if (accept) begin
                req_we_q    <= cpu_we;
                req_byte_q  <= cpu_byte;
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
            end
        end
    end

    // Shadow tags are only read when the line is dirty, so they need no reset.
    always_ff @(posedge clock) begin
        if (!reset && shadow_we) shadow_tag_q[idx] <= req_tag;
    end

`ifdef CACHE_CTRL_STATS_EN
    logic              first_q;
    logic [STAT_W-1:0] hits_q, misses_q;

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

    // Count each request once, at its first compare; the post-fill retry is skipped.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_q  <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (accept) begin
                first_q <= 1'b1;
            end else if (state_q == StCompare) begin
                first_q <= 1'b0;
                if (first_q) begin
                    if (hit) begin
                        if (!(&hits_q)) hits_q <= hits_q + 1'b1;
                    end else begin
                        if (!(&misses_q)) misses_q <= misses_q + 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: behavioural cache array and memory models,
// directed CPU requests with hand-computed responses queued at issue time and
// checked by independent CPU and memory monitors.
module tb_cache_ctrl;

    logic         clock;
    logic         reset;
    logic         cpu_req, cpu_we, cpu_byte;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_done;
    logic         c_write, c_comp, c_byte_access;
    logic [1:0]   c_index, c_word, c_byte;
    logic [25:0]  c_tag;
    logic [31:0]  c_wdata, c_rdata;
    logic         c_hit, c_valid;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    cache_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .c_write(c_write), .c_comp(c_comp), .c_byte_access(c_byte_access),
        .c_index(c_index), .c_word(c_word), .c_byte(c_byte),
        .c_tag(c_tag), .c_wdata(c_wdata),
        .c_hit(c_hit), .c_valid(c_valid), .c_rdata(c_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic chk; logic [31:0] rdata; } cpu_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [127:0] wdata; } mem_exp_t;

    cpu_exp_t cpu_q [$];
    mem_exp_t mem_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int mem_req_cycles = 0;
    int fill_wr_cnt = 0;
    int ack_delay = 0;

    logic [127:0] mem_line [logic [31:0]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [127:0] wd);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    // mode 1: single-compare completion (latency 2, no memory); mode 2: no memory only.
    task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wd, input logic chk, input logic [31:0] exp,
                          input int mode);
        int accept, d0, m0;
        cpu_exp_t e;
        @(negedge clock);
        e.chk = chk; e.rdata = exp;
        cpu_q.push_back(e);
        cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        accept = cyc + 1;
        d0 = done_cnt;
        m0 = mem_req_cycles;
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            @(negedge clock);
            #1;
        end
        cpu_req = 1'b0;
        check("done_seen", done_cnt != d0, 1'b1);
        if (mode == 1) check("hit_latency", last_done_cyc + 1 - accept, 2);
        if (mode >= 1) check("no_mem_req", mem_req_cycles - m0, 0);
    endtask

    // Behavioural cache array: combinational read/hit, write on the clock edge.
    logic [31:0] arr_data [4][4];
    logic [25:0] arr_tag [4];
    logic [3:0]  arr_valid;

    assign c_valid = arr_valid[c_index];
    assign c_hit   = c_comp && arr_valid[c_index] && (arr_tag[c_index] == c_tag);
    assign c_rdata = arr_data[c_index][c_word];

    // Array storage update.
    always @(posedge clock) begin
        if (reset) begin
            arr_valid <= 4'b0000;
        end else if (c_write) begin
            if (!c_comp) begin
                arr_data[c_index][c_word] <= c_wdata;
                arr_tag[c_index]          <= c_tag;
                arr_valid[c_index]        <= 1'b1;
            end else if (c_hit) begin
                arr_data[c_index][c_word] <= c_wdata;
            end
        end
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // CPU-side monitor: pop the expected response on every completion pulse.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clock);
            if (cpu_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (cpu_q.size() == 0) begin
                    check("unexpected_done", cpu_done, 1'b0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.chk) check("load_rdata", cpu_rdata, e.rdata);
                end
            end
        end
    end

    // Memory model and monitor: programmable ack delay, stability and ordering checks.
    initial begin
        logic         busy, stable, cap_we;
        logic [31:0]  cap_addr;
        logic [127:0] cap_wdata;
        int           wait_cnt;
        mem_exp_t     e;
        busy = 1'b0; stable = 1'b1; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
        wait_cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (c_write && !c_comp) fill_wr_cnt++;
            if (mem_req) mem_req_cycles++;
            if (reset) begin
                mem_ack = 1'b0;
                busy = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                check("req_low_after_ack", mem_req, 1'b0);
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1; wait_cnt = 0; stable = 1'b1;
                    cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                end else begin
                    if (mem_we !== cap_we || mem_addr !== cap_addr || mem_wdata !== cap_wdata)
                        stable = 1'b0;
                    wait_cnt++;
                end
                if (wait_cnt >= ack_delay) begin
                    busy = 1'b0;
                    mem_ack = 1'b1;
                    if (cap_we) mem_line[cap_addr] = cap_wdata;
                    else mem_rdata = mem_line.exists(cap_addr) ? mem_line[cap_addr] : '0;
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_txn", mem_req, 1'b0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_we", cap_we, e.we);
                        check("mem_addr", cap_addr, e.addr);
                        if (e.we) check("mem_wdata", cap_wdata, e.wdata);
                        check("mem_stable", stable, 1'b1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int d0, f0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_line[32'h10] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        mem_line[32'h50] = {32'h77777777, 32'h66666666, 32'h55555555, 32'h0BADC0DE};
        mem_line[32'h90] = {32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999, 32'h88888888};
        repeat (3) @(negedge clock);
        check("rst_cpu_done", cpu_done, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_c_write", c_write, 1'b0);
        check("rst_c_comp", c_comp, 1'b0);
        check("rst_c_byte_access", c_byte_access, 1'b0);
        reset = 1'b0;

        // Cold load: fetch line 0x10, four fill writes, then retry hit.
        ack_delay = 1;
        push_mem(1'b0, 32'h10, '0);
        f0 = fill_wr_cnt;
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 0);
        check("cold_fill_writes", fill_wr_cnt - f0, 4);

        // Hits: load, byte store merge, word store, word and byte loads.
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1);
        do_req(1'b1, 1'b1, 32'h11, 32'h5A, 1'b0, 32'h0, 2);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD5AEF, 1);
        do_req(1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0, 1);
        do_req(1'b0, 1'b0, 32'h14, 32'h0, 1'b1, 32'hCAFEF00D, 1);
        do_req(1'b0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1);

        // Conflict miss on dirty line 1: write-back of 0x10 then fill of 0x50, slow ack.
        ack_delay = 7;
        push_mem(1'b1, 32'h10, {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'hDEAD5AEF});
        push_mem(1'b0, 32'h50, '0);
        f0 = fill_wr_cnt;
        do_req(1'b0, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0BADC0DE, 0);
        check("wb_fill_writes", fill_wr_cnt - f0, 4);

        // Line now clean: re-fetch of 0x10 returns the written-back data, no write-back.
        ack_delay = 0;
        push_mem(1'b0, 32'h10, '0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD5AEF, 0);

        // Reset while a fill is outstanding.
        ack_delay = 50;
        @(negedge clock);
        cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h90; cpu_req = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            @(negedge clock);
            #1;
        end
        check("abort_fill_req", mem_req, 1'b1);
        check("abort_fill_addr", mem_addr, 32'h90);
        check("abort_fill_we", mem_we, 1'b0);
        d0 = done_cnt;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clock);
        #1;
        check("abort_mem_req_low", mem_req, 1'b0);
        check("abort_c_write_low", c_write, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_mem_req", mem_req, 1'b0);

        // Normal operation after the abort (array cleared, cold miss).
        ack_delay = 2;
        push_mem(1'b0, 32'h50, '0);
        do_req(1'b0, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0BADC0DE, 0);
        do_req(1'b0, 1'b0, 32'h50, 32'h0, 1'b1, 32'h0BADC0DE, 1);

        repeat (5) @(negedge clock);
        check("cpu_queue_drained", cpu_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
